bomb_blast_ctrl: RTL and testbench

Single-bomb lifecycle controller and drawing object for the Bomber-Man VGA pipeline. Captures a bomb-placement request at the player's tile, runs a frame-based fuse, then a cross-shaped blast clipped by borders and pillars. Per pixel it produces the bomb and blast draw-request/RGB pairs consumed directly by the object priority mux, plus blast geometry for collision logic.

---
 rtl/bomberman_pkg.sv | 30 +++
 rtl/blast_arm_calc.sv | 53 +++++
 rtl/bomb_blast_ctrl.sv | 159 +++++++++++++++
 tb/tb_bomb_blast_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared grid geometry, FSM state type, palette and tile classification for the
// Bomber-Man object pipeline.
package bomberman_pkg;

  localparam int TILE_SHIFT = 5;
  localparam int GRID_W     = 20;
  localparam int GRID_H     = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CALC  = 2'd2,
    BLAST = 2'd3
  } state_t;

  localparam logic [7:0] BOMB_RGB       = 8'h24;
  localparam logic [7:0] BOMB_BLINK_RGB = 8'hE0;
  localparam logic [7:0] BLAST_CORE_RGB = 8'hFC;
  localparam logic [7:0] BLAST_ARM_RGB  = 8'hF0;

  function automatic logic is_border(input logic [4:0] tx, input logic [3:0] ty);
    return (tx == 5'd0) || (tx == 5'(GRID_W - 1)) ||
           (ty == 4'd0) || (ty == 4'(GRID_H - 1));
  endfunction

  function automatic logic is_pillar(input logic [4:0] tx, input logic [3:0] ty);
    return !is_border(tx, ty) && !tx[0] && !ty[0];
  endfunction

endpackage

// File: rtl/blast_arm_calc.sv
// Registered clip of the four blast arms against the playfield border and the
// pillar lattice; captures only while en is high.
module blast_arm_calc
  import bomberman_pkg::*;
#(
  parameter int RADIUS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [4:0] tileX,
  input  logic [3:0] tileY,
  output logic [2:0] armL,
  output logic [2:0] armR,
  output logic [2:0] armU,
  output logic [2:0] armD
);

  localparam logic signed [5:0] RAD = 6'(RADIUS);

  logic signed [5:0] tx;
  logic signed [5:0] ty;

  // Saturate the free room in one direction to [0, RADIUS].
  function automatic logic [2:0] clip(input logic signed [5:0] room);
    if (room <= 6'sd0)
      return 3'd0;
    else if (room < RAD)
      return room[2:0];
    else
      return RAD[2:0];
  endfunction

  assign tx = signed'({1'b0, tileX});
  assign ty = signed'({2'b0, tileY});

  // Horizontal arms die on an even row and vertical arms on an even column,
  // because the neighbouring tiles there are pillars.
  always_ff @(posedge clk) begin
    if (reset) begin
      armL <= '0;
      armR <= '0;
      armU <= '0;
      armD <= '0;
    end else if (en) begin
      armL <= tileY[0] ? clip(tx - 6'sd1)  : 3'd0;
      armR <= tileY[0] ? clip(6'sd18 - tx) : 3'd0;
      armU <= tileX[0] ? clip(ty - 6'sd1)  : 3'd0;
      armD <= tileX[0] ? clip(6'sd13 - ty) : 3'd0;
    end
  end

endmodule

// File: rtl/bomb_blast_ctrl.sv
// Single-bomb lifecycle FSM plus bomb/blast drawing objects.
// Optional build macro BOMB_BLINK_EN makes the bomb flash near the end of its fuse.
module bomb_blast_ctrl
  import bomberman_pkg::*;
#(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int RADIUS       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        placeBomb,
  input  logic [4:0]  playerTileX,
  input  logic [3:0]  playerTileY,
  input  logic        detonateNow,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        bombDR,
  output logic [7:0]  bombRGB,
  output logic        blastDR,
  output logic [7:0]  blastRGB,
  output logic        blastActive,
  output logic [4:0]  bombTileX,
  output logic [3:0]  bombTileY,
  output logic [2:0]  armL,
  output logic [2:0]  armR,
  output logic [2:0]  armU,
  output logic [2:0]  armD
);

  localparam int CNT_W = 16;

  state_t           state;
  logic [CNT_W-1:0] fuseCnt;
  logic [CNT_W-1:0] blastCnt;
  logic             place_ok;

  assign place_ok = (playerTileX < 5'(GRID_W)) && (playerTileY < 4'(GRID_H)) &&
                    !is_border(playerTileX, playerTileY) &&
                    !is_pillar(playerTileX, playerTileY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fuseCnt   <= '0;
      blastCnt  <= '0;
      bombTileX <= '0;
      bombTileY <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (placeBomb && place_ok) begin
            bombTileX <= playerTileX;
            bombTileY <= playerTileY;
            fuseCnt   <= CNT_W'(FUSE_FRAMES);
            state     <= ARMED;
          end
        end
        ARMED: begin
          // A forced detonation wins over a coincident frame tick.
          if (detonateNow) begin
            state <= CALC;
          end else if (startOfFrame) begin
            if (fuseCnt <= CNT_W'(1)) begin
              fuseCnt <= '0;
              state   <= CALC;
            end else begin
              fuseCnt <= fuseCnt - CNT_W'(1);
            end
          end
        end
        CALC: begin
          blastCnt <= CNT_W'(BLAST_FRAMES);
          state    <= BLAST;
        end
        BLAST: begin
          if (startOfFrame) begin
            if (blastCnt <= CNT_W'(1)) begin
              blastCnt <= '0;
              state    <= IDLE;
            end else begin
              blastCnt <= blastCnt - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blastActive = (state == BLAST);

  blast_arm_calc #(
    .RADIUS(RADIUS)
  ) u_arm_calc (
    .clk  (clk),
    .reset(reset),
    .en   (state == CALC),
    .tileX(bombTileX),
    .tileY(bombTileY),
    .armL (armL),
    .armR (armR),
    .armU (armU),
    .armD (armD)
  );

  // Stage p0: pixel-to-tile hit tests in signed 6-bit tile space.
  logic              in_grid_p0;
  logic signed [5:0] ptx_p0, pty_p0, btx_p0, bty_p0;
  logic signed [5:0] al_p0, ar_p0, au_p0, ad_p0;
  logic              on_tile_p0, on_row_p0, on_col_p0;
  logic              bomb_hit_p0, blast_hit_p0;
  logic [7:0]        bomb_col_p0;

  assign in_grid_p0 = (pixelX < 11'(GRID_W << TILE_SHIFT)) &&
                      (pixelY < 11'(GRID_H << TILE_SHIFT));
  assign ptx_p0 = signed'({1'b0, pixelX[9:5]});
  assign pty_p0 = signed'({2'b0, pixelY[8:5]});
  assign btx_p0 = signed'({1'b0, bombTileX});
  assign bty_p0 = signed'({2'b0, bombTileY});
  assign al_p0  = signed'({3'b0, armL});
  assign ar_p0  = signed'({3'b0, armR});
  assign au_p0  = signed'({3'b0, armU});
  assign ad_p0  = signed'({3'b0, armD});

  assign on_tile_p0 = (ptx_p0 == btx_p0) && (pty_p0 == bty_p0);
  assign on_row_p0  = (pty_p0 == bty_p0) &&
                      (ptx_p0 >= btx_p0 - al_p0) && (ptx_p0 <= btx_p0 + ar_p0);
  assign on_col_p0  = (ptx_p0 == btx_p0) &&
                      (pty_p0 >= bty_p0 - au_p0) && (pty_p0 <= bty_p0 + ad_p0);

  assign bomb_hit_p0 = (state == ARMED) && in_grid_p0 && on_tile_p0 &&
                       (pixelX[4:0] >= 5'd4) && (pixelX[4:0] <= 5'd27) &&
                       (pixelY[4:0] >= 5'd4) && (pixelY[4:0] <= 5'd27);
  assign blast_hit_p0 = (state == BLAST) && in_grid_p0 && (on_row_p0 || on_col_p0);

`ifdef BOMB_BLINK_EN
  assign bomb_col_p0 = ((fuseCnt <= CNT_W'(32)) && fuseCnt[2]) ? BOMB_BLINK_RGB : BOMB_RGB;
`else
  assign bomb_col_p0 = BOMB_RGB;
`endif

  // Stage p1: registered draw requests and colours for the priority mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      bombDR   <= 1'b0;
      bombRGB  <= '0;
      blastDR  <= 1'b0;
      blastRGB <= '0;
    end else begin
      bombDR   <= bomb_hit_p0;
      bombRGB  <= bomb_hit_p0 ? bomb_col_p0 : 8'h00;
      blastDR  <= blast_hit_p0;
      blastRGB <= blast_hit_p0 ? (on_tile_p0 ? BLAST_CORE_RGB : BLAST_ARM_RGB) : 8'h00;
    end
  end

endmodule

// File: tb/tb_bomb_blast_ctrl.sv
// Directed bench for bomb_blast_ctrl with FUSE_FRAMES=4, BLAST_FRAMES=3, RADIUS=2.
module tb_bomb_blast_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        placeBomb = 1'b0;
  logic [4:0]  playerTileX = '0;
  logic [3:0]  playerTileY = '0;
  logic        detonateNow = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        bombDR, blastDR, blastActive;
  logic [7:0]  bombRGB, blastRGB;
  logic [4:0]  bombTileX;
  logic [3:0]  bombTileY;
  logic [2:0]  armL, armR, armU, armD;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bomb_blast_ctrl #(
    .FUSE_FRAMES (4),
    .BLAST_FRAMES(3),
    .RADIUS      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .placeBomb   (placeBomb),
    .playerTileX (playerTileX),
    .playerTileY (playerTileY),
    .detonateNow (detonateNow),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .bombDR      (bombDR),
    .bombRGB     (bombRGB),
    .blastDR     (blastDR),
    .blastRGB    (blastRGB),
    .blastActive (blastActive),
    .bombTileX   (bombTileX),
    .bombTileY   (bombTileY),
    .armL        (armL),
    .armR        (armR),
    .armU        (armU),
    .armD        (armD)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  task automatic place(input int x, input int y);
    playerTileX = 5'(x);
    playerTileY = 4'(y);
    placeBomb = 1'b1;
    tick();
    placeBomb = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bombDR, bombRGB, blastDR, blastRGB, blastActive, bombTileX, bombTileY,
         armL, armR, armU, armD} !== 47'd0) begin
      fails++;
      $display("FAIL reset_outputs: got dr=%0d rgb=%0h bdr=%0d brgb=%0h act=%0d tile=%0d,%0d arms=%0d%0d%0d%0d expected all 0",
               bombDR, bombRGB, blastDR, blastRGB, blastActive, bombTileX, bombTileY, armL, armR, armU, armD);
    end
  endtask

  task automatic test_fuse();
    set_pix(176, 176);
    place(5, 5);
    checks++; if (bombDR !== 1'b0) begin fails++; $display("FAIL fuse_bombDR_latency: got %0d expected 0", bombDR); end
    checks++; if ({bombTileX, bombTileY} !== {5'd5, 4'd5}) begin fails++; $display("FAIL fuse_tile_latch: got %0d,%0d expected 5,5", bombTileX, bombTileY); end
    tick();
    checks++; if ({bombDR, bombRGB} !== {1'b1, 8'h24}) begin fails++; $display("FAIL fuse_bomb_centre: got dr=%0d rgb=%0h expected 1/24", bombDR, bombRGB); end
    set_pix(163, 176);
    tick();
    checks++; if ({bombDR, bombRGB} !== 9'd0) begin fails++; $display("FAIL fuse_bomb_off3: got dr=%0d rgb=%0h expected 0/0", bombDR, bombRGB); end
    set_pix(187, 187);
    tick();
    checks++; if (bombDR !== 1'b1) begin fails++; $display("FAIL fuse_bomb_off27: got %0d expected 1", bombDR); end
    set_pix(188, 176);
    tick();
    checks++; if (bombDR !== 1'b0) begin fails++; $display("FAIL fuse_bomb_off28: got %0d expected 0", bombDR); end
    place(7, 7);
    checks++; if ({bombTileX, bombTileY} !== {5'd5, 4'd5}) begin fails++; $display("FAIL armed_replace_ignored: got %0d,%0d expected 5,5", bombTileX, bombTileY); end
    for (int i = 0; i < 3; i++) begin
      sof();
      checks++; if (blastActive !== 1'b0) begin fails++; $display("FAIL fuse_still_armed_%0d: got %0d expected 0", i, blastActive); end
    end
    sof();
    checks++; if (blastActive !== 1'b0) begin fails++; $display("FAIL fuse_calc_cycle: got %0d expected 0", blastActive); end
    tick();
    checks++; if (blastActive !== 1'b1) begin fails++; $display("FAIL fuse_blast_start: got %0d expected 1", blastActive); end
    checks++; if ({armL, armR, armU, armD} !== {3'd2, 3'd2, 3'd2, 3'd2}) begin fails++; $display("FAIL fuse_arms: got %0d %0d %0d %0d expected 2 2 2 2", armL, armR, armU, armD); end
    set_pix(176, 176);
    tick();
    checks++; if ({blastDR, blastRGB, bombDR} !== {1'b1, 8'hFC, 1'b0}) begin fails++; $display("FAIL blast_centre: got dr=%0d rgb=%0h bomb=%0d expected 1/fc/0", blastDR, blastRGB, bombDR); end
    set_pix(240, 176);
    tick();
    checks++; if ({blastDR, blastRGB} !== {1'b1, 8'hF0}) begin fails++; $display("FAIL blast_right_end: got dr=%0d rgb=%0h expected 1/f0", blastDR, blastRGB); end
    set_pix(272, 176);
    tick();
    checks++; if ({blastDR, blastRGB} !== 9'd0) begin fails++; $display("FAIL blast_right_beyond: got dr=%0d rgb=%0h expected 0/0", blastDR, blastRGB); end
    set_pix(176, 112);
    tick();
    checks++; if ({blastDR, blastRGB} !== {1'b1, 8'hF0}) begin fails++; $display("FAIL blast_up_end: got dr=%0d rgb=%0h expected 1/f0", blastDR, blastRGB); end
    sof();
    sof();
    checks++; if (blastActive !== 1'b1) begin fails++; $display("FAIL blast_hold: got %0d expected 1", blastActive); end
    sof();
    checks++; if (blastActive !== 1'b0) begin fails++; $display("FAIL blast_end: got %0d expected 0", blastActive); end
  endtask

  task automatic test_corner();
    place(1, 1);
    detonateNow = 1'b1;
    tick();
    detonateNow = 1'b0;
    tick();
    checks++; if ({armL, armR, armU, armD} !== {3'd0, 3'd2, 3'd0, 3'd2}) begin fails++; $display("FAIL corner_arms: got %0d %0d %0d %0d expected 0 2 0 2", armL, armR, armU, armD); end
    set_pix(32, 64);
    tick();
    checks++; if ({blastDR, blastRGB} !== {1'b1, 8'hF0}) begin fails++; $display("FAIL corner_down: got dr=%0d rgb=%0h expected 1/f0", blastDR, blastRGB); end
    set_pix(0, 32);
    tick();
    checks++; if (blastDR !== 1'b0) begin fails++; $display("FAIL corner_border: got %0d expected 0", blastDR); end
    set_pix(96, 32);
    tick();
    checks++; if (blastDR !== 1'b1) begin fails++; $display("FAIL corner_right_end: got %0d expected 1", blastDR); end
    do_reset();
  endtask

  task automatic test_even_row();
    place(3, 4);
    detonateNow = 1'b1;
    tick();
    detonateNow = 1'b0;
    tick();
    checks++; if ({armL, armR, armU, armD} !== {3'd0, 3'd0, 3'd2, 3'd2}) begin fails++; $display("FAIL even_row_arms: got %0d %0d %0d %0d expected 0 0 2 2", armL, armR, armU, armD); end
    set_pix(128, 144);
    tick();
    checks++; if (blastDR !== 1'b0) begin fails++; $display("FAIL even_row_side: got %0d expected 0", blastDR); end
    set_pix(96, 192);
    tick();
    checks++; if (blastDR !== 1'b1) begin fails++; $display("FAIL even_row_down: got %0d expected 1", blastDR); end
    do_reset();
  endtask

  task automatic test_pillar();
    set_pix(144, 144);
    place(4, 4);
    checks++; if ({bombTileX, bombTileY} !== 9'd0) begin fails++; $display("FAIL pillar_tile: got %0d,%0d expected 0,0", bombTileX, bombTileY); end
    tick();
    checks++; if (bombDR !== 1'b0) begin fails++; $display("FAIL pillar_bombDR: got %0d expected 0", bombDR); end
    place(0, 5);
    checks++; if ({bombTileX, bombTileY} !== 9'd0) begin fails++; $display("FAIL border_tile: got %0d,%0d expected 0,0", bombTileX, bombTileY); end
    detonateNow = 1'b1;
    tick();
    detonateNow = 1'b0;
    tick();
    checks++; if (blastActive !== 1'b0) begin fails++; $display("FAIL idle_detonate_ignored: got %0d expected 0", blastActive); end
  endtask

  task automatic test_sof_detonate_and_reset();
    place(5, 5);
    sof();
    startOfFrame = 1'b1;
    detonateNow = 1'b1;
    tick();
    startOfFrame = 1'b0;
    detonateNow = 1'b0;
    checks++; if (blastActive !== 1'b0) begin fails++; $display("FAIL det_calc_cycle: got %0d expected 0", blastActive); end
    tick();
    checks++; if (blastActive !== 1'b1) begin fails++; $display("FAIL det_blast_start: got %0d expected 1", blastActive); end
    set_pix(176, 176);
    tick();
    checks++; if (blastDR !== 1'b1) begin fails++; $display("FAIL det_blast_centre: got %0d expected 1", blastDR); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bombDR, bombRGB, blastDR, blastRGB, blastActive, bombTileX, bombTileY,
         armL, armR, armU, armD} !== 47'd0) begin
      fails++;
      $display("FAIL reset_mid_blast: got dr=%0d bdr=%0d brgb=%0h act=%0d tile=%0d,%0d expected all 0",
               bombDR, blastDR, blastRGB, blastActive, bombTileX, bombTileY);
    end
    place(9, 7);
    checks++; if ({bombTileX, bombTileY} !== {5'd9, 4'd7}) begin fails++; $display("FAIL replace_after_reset: got %0d,%0d expected 9,7", bombTileX, bombTileY); end
    set_pix(304, 240);
    tick();
    checks++; if ({bombDR, bombRGB} !== {1'b1, 8'h24}) begin fails++; $display("FAIL replace_bombDR: got dr=%0d rgb=%0h expected 1/24", bombDR, bombRGB); end
  endtask

  initial begin
    test_reset();
    test_fuse();
    test_corner();
    test_even_row();
    do_reset();
    test_pillar();
    test_sof_detonate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
